// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked word stores and word loads, answered in order
// after a fixed latency, with a bounded response buffer to absorb back-pressure.
module dmem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_we
);
  localparam int IW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_pv [LATENCY];
  logic [DATA_WIDTH-1:0] r_pd [LATENCY];
  logic                  r_pe [LATENCY];
  logic                  r_pw [LATENCY];

  logic [DATA_WIDTH-1:0] r_fd [RSP_DEPTH];
  logic                  r_fe [RSP_DEPTH];
  logic                  r_fw [RSP_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_fcount;
  logic [CW-1:0]         r_outstanding;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_err;
  logic                  w_wr;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign req_ready = (r_outstanding < CW'(RSP_DEPTH));
  assign rsp_valid = (r_fcount != '0);
  assign w_accept  = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_push    = r_pv[LATENCY-1];
  assign w_idx     = req_addr[3 +: IW];
  assign w_err     = (req_addr[2:0] != 3'b000) ||
                     (req_addr[ADDR_WIDTH-1:3] >= (ADDR_WIDTH-3)'(DEPTH));
  assign w_wr      = w_accept && req_we && !w_err;
  assign w_rdata   = (req_we || w_err) ? '0 : r_mem[w_idx];

  // Array is deliberately not reset so stored words survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (req_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pe[i] <= 1'b0;
        r_pw[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pd[0] <= w_rdata;
      r_pe[0] <= w_err;
      r_pw[0] <= req_we;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pw[i] <= r_pw[i-1];
      end
    end
  end

  // The outstanding limit guarantees the buffer has room whenever the pipeline delivers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fd[r_wptr] <= r_pd[LATENCY-1];
      r_fe[r_wptr] <= r_pe[LATENCY-1];
      r_fw[r_wptr] <= r_pw[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_fcount      <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PW'(RSP_DEPTH-1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(RSP_DEPTH-1)) ? '0 : r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fcount <= r_fcount + CW'(1);
        2'b01:   r_fcount <= r_fcount - CW'(1);
        default: r_fcount <= r_fcount;
      endcase
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign rsp_rdata = rsp_valid ? r_fd[r_rptr] : '0;
  assign rsp_err   = rsp_valid ? r_fe[r_rptr] : 1'b0;
  assign rsp_we    = rsp_valid ? r_fw[r_rptr] : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a negedge monitor keeps a scoreboard of
// expected responses (with a word-level memory model) and scenario tasks check control.
module tb_dmem_responder;
  localparam int DEPTH     = 1024;
  localparam int LATENCY   = 2;
  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_we;

  typedef struct {
    logic        we;
    logic        err;
    logic [63:0] rdata;
    int          accEdge;
    bit          chkLat;
  } rsp_t;

  rsp_t        expQ[$];
  logic [63:0] model [int];
  int          popCycles[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          accCount = 0;
  bit          latCheck = 1'b0;
  bit          streamMode = 1'b0;

  dmem_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_we(rsp_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sampled mid-cycle: whatever is seen here is what the next rising edge acts on.
  always @(negedge clk) begin
    rsp_t e;
    int   idx;
    if (!reset) begin
      expQ.delete();
    end else begin
      if (rsp_valid) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_rsp: got rdata=%h err=%b we=%b, required no response",
                   rsp_rdata, rsp_err, rsp_we);
        end else begin
          e = expQ[0];
          if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_we !== e.we) begin
            failures++;
            $display("[TB] FAIL rsp_payload: got rdata=%h err=%b we=%b, required rdata=%h err=%b we=%b",
                     rsp_rdata, rsp_err, rsp_we, e.rdata, e.err, e.we);
          end
          if (rsp_ready) begin
            void'(expQ.pop_front());
            if (streamMode) popCycles.push_back(cyc);
            if (e.chkLat) begin
              checks++;
              if (cyc - e.accEdge !== LATENCY) begin
                failures++;
                $display("[TB] FAIL rsp_latency: got %0d cycles, required %0d", cyc - e.accEdge, LATENCY);
              end
            end
          end
        end
      end
      if (req_valid && req_ready) begin
        accCount++;
        idx       = int'(req_addr >> 3);
        e.we      = req_we;
        e.err     = (req_addr[2:0] != 3'b000) || (req_addr >= 32'(DEPTH * 8));
        e.accEdge = cyc + 1;
        e.chkLat  = latCheck;
        e.rdata   = '0;
        if (!e.err && req_we) begin
          if (!model.exists(idx)) model[idx] = '0;
          for (int b = 0; b < 8; b++) begin
            if (req_wmask[b]) model[idx][8*b +: 8] = req_wdata[8*b +: 8];
          end
        end else if (!e.err) begin
          e.rdata = model.exists(idx) ? model[idx] : 64'hx;
        end
        expQ.push_back(e);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitAccept(input string name);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("[TB] FAIL %s_accept: got req_ready=%b after %0d cycles, required 1", name, req_ready, n);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic sendReq(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [7:0] mask, input string name);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    req_valid = 1'b1;
    waitAccept(name);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((expQ.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0 || rsp_valid) begin
      failures++;
      $display("[TB] FAIL %s_drain: got %0d pending rsp_valid=%b, required 0 pending", name, expQ.size(), rsp_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %b, required 1", req_ready); end
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    if (rsp_rdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_rsp_rdata: got %h, required 0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_err: got %b, required 0", rsp_err); end
    if (rsp_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_we: got %b, required 0", rsp_we); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_req_ready: got %b, required 1", req_ready); end
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_rsp_valid: got %b, required 0", rsp_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_init();
    latCheck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sendReq(1'b1, 32'(i * 8), 64'h0101010101010101 * 64'(i + 1), 8'hFF, "init");
    end
    waitIdle("init");
  endtask

  task automatic test_store_load();
    int n = 0;
    latCheck = 1'b1;
    sendReq(1'b1, 32'h10, 64'h1122334455667788, 8'hFF, "sl_store");
    sendReq(1'b0, 32'h10, 64'h0, 8'h00, "sl_load");
    while (!(rsp_valid && !rsp_we) && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_rdata !== 64'h1122334455667788) begin
      failures++;
      $display("[TB] FAIL store_load_data: got %h, required 1122334455667788", rsp_rdata);
    end
    waitIdle("store_load");
  endtask

  task automatic test_mask_merge();
    int n = 0;
    latCheck = 1'b1;
    sendReq(1'b1, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, "mm_store");
    sendReq(1'b0, 32'h10, 64'h0, 8'h00, "mm_load");
    while (!(rsp_valid && !rsp_we) && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_rdata !== 64'h11223344AAAAAAAA) begin
      failures++;
      $display("[TB] FAIL mask_merge_data: got %h, required 11223344aaaaaaaa", rsp_rdata);
    end
    waitIdle("mask_merge");
  endtask

  task automatic test_errors();
    latCheck = 1'b1;
    sendReq(1'b0, 32'h13, 64'h0, 8'h00, "err_misaligned");
    sendReq(1'b0, 32'h2000, 64'h0, 8'h00, "err_range_load");
    sendReq(1'b1, 32'h2000, 64'hDEADBEEFCAFEF00D, 8'hFF, "err_range_store");
    sendReq(1'b0, 32'h0, 64'h0, 8'h00, "err_word0");
    waitIdle("errors");
  endtask

  task automatic test_back_pressure();
    int base;
    latCheck  = 1'b0;
    rsp_ready = 1'b0;
    base      = accCount;
    for (int i = 0; i < 4; i++) begin
      sendReq(1'b0, 32'(i * 8), 64'h0, 8'h00, "bp_fill");
    end
    req_we    = 1'b0;
    req_addr  = 32'h20;
    req_valid = 1'b1;
    repeat (5) @(negedge clk);
    checks += 2;
    if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_ready: got %b, required 0", req_ready); end
    if (accCount - base !== 4) begin failures++; $display("[TB] FAIL bp_accept_count: got %0d, required 4", accCount - base); end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_before_pop: got %b, required 0", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_after_pop: got %b, required 1", req_ready); end
    waitAccept("bp_fifth");
    sendReq(1'b0, 32'h28, 64'h0, 8'h00, "bp_sixth");
    waitIdle("back_pressure");
  endtask

  task automatic test_back_to_back();
    int a0;
    latCheck   = 1'b1;
    streamMode = 1'b1;
    popCycles.delete();
    a0 = cyc;
    for (int i = 0; i < 16; i++) begin
      sendReq(1'b0, 32'((i % 6) * 8), 64'h0, 8'h00, "stream");
    end
    checks++;
    if (cyc - a0 !== 16) begin failures++; $display("[TB] FAIL stream_accept_cycles: got %0d, required 16", cyc - a0); end
    waitIdle("stream");
    streamMode = 1'b0;
    checks++;
    if (popCycles.size() !== 16) begin
      failures++;
      $display("[TB] FAIL stream_rsp_count: got %0d, required 16", popCycles.size());
    end else begin
      checks++;
      if (popCycles[15] - popCycles[0] !== 15) begin
        failures++;
        $display("[TB] FAIL stream_no_bubbles: got span %0d, required 15", popCycles[15] - popCycles[0]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    latCheck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sendReq(1'b0, 32'(i * 8), 64'h0, 8'h00, "rst_load");
    end
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_rsp_valid: got %b, required 0", rsp_valid); end
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_req_ready: got %b, required 1", req_ready); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin failures++; $display("[TB] FAIL midrst_stale: got %0d stale cycles, required 0", stale); end
    @(posedge clk);
    #1;
    latCheck = 1'b1;
    sendReq(1'b0, 32'h10, 64'h0, 8'h00, "rst_retained");
    waitIdle("reset_midflight");
  endtask

  initial begin
    $display("[TB] starting dmem_responder bench");
    test_reset();
    test_init();
    test_store_load();
    test_mask_merge();
    test_errors();
    test_back_pressure();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
